// File: rtl/wiretrace_pkg.sv
// +-----------------------------------------------------------------------------
// | wiretrace_pkg : record encoding constants and capture FSM states shared by
// |                 wire_capture, the trace FIFO and the downstream decoder.
// | Revision      : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package wiretrace_pkg;

   localparam int DEF_NPROBES = 32;
   localparam int DEF_TSBITS  = 8;
   localparam int DEF_WIDTH   = DEF_TSBITS + DEF_NPROBES;
   localparam int DROP_W      = 16;

   localparam logic [DEF_TSBITS-1:0] DMAX      = {DEF_TSBITS{1'b1}};
   localparam logic [DEF_TSBITS-1:0] D_OVF     = '0;
   localparam logic [DROP_W-1:0]     DROPS_SAT = {DROP_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_OVF   = 3'd4
   } state_t;

   function automatic logic [DROP_W-1:0] drops_inc(input logic [DROP_W-1:0] d);
      return (d == DROPS_SAT) ? d : d + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wire_capture_if.sv
// +-----------------------------------------------------------------------------
// | wire_capture_if : probe bus and single-cycle FIFO write port of wire_capture.
// |                   Trigger signals exist only with WIRE_CAPTURE_TRIG_EN.
// | Revision        : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface wire_capture_if #(
   parameter int nprobes = 32,
   parameter int tsbits  = 8,
   parameter int width   = tsbits + nprobes
);
   logic [nprobes-1:0] probe;
   logic               full;
   logic [width-1:0]   out;
   logic               ine;

`ifdef WIRE_CAPTURE_TRIG_EN
   logic [nprobes-1:0] trig_mask;
   logic [nprobes-1:0] trig_value;

   modport master (input probe, full, trig_mask, trig_value, output out, ine);
   modport slave  (output probe, full, trig_mask, trig_value, input out, ine);
`else
   modport master (input probe, full, output out, ine);
   modport slave  (output probe, full, input out, ine);
`endif

endinterface

`default_nettype wire

// File: rtl/capture_delta.sv
// +-----------------------------------------------------------------------------
// | capture_delta : saturating cycles-since-last-record counter, load-to-1 and
// |                 DMAX flag. Resets to 1.
// | Revision      : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module capture_delta #(
   parameter int tsbits = 8
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              load1,
   input  wire logic              inc,
   output logic [tsbits-1:0]      cnt,
   output logic                   at_max
);

   localparam logic [tsbits-1:0] c_one  = {{(tsbits-1){1'b0}}, 1'b1};
   localparam logic [tsbits-1:0] c_dmax = {tsbits{1'b1}};

   logic [tsbits-1:0] cnt_q;
   logic [tsbits-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load1) begin
         cnt_d = c_one;
      end else if (inc && (cnt_q != c_dmax)) begin
         cnt_d = cnt_q + c_one;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= c_one;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign at_max = (cnt_q == c_dmax);

endmodule

`default_nettype wire

// File: rtl/wire_capture.sv
// +-----------------------------------------------------------------------------
// | wire_capture : registers probe wires and writes time-delta, keepalive and
// |                overflow records into the trace FIFO. Option: WIRE_CAPTURE_TRIG_EN.
// | Revision     : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module wire_capture
   import wiretrace_pkg::*;
#(
   parameter int nprobes = 32,
   parameter int tsbits  = 8,
   parameter int width   = tsbits + nprobes
) (
   input  wire logic      clk,
   input  wire logic      reset,
   input  wire logic      arm,
   wire_capture_if.master bus
);

   localparam logic [tsbits-1:0] c_dmax  = {tsbits{1'b1}};
   localparam logic [tsbits-1:0] c_d_ovf = '0;

   state_t               state_q, state_d;
   logic [nprobes-1:0]   sample_q, sample_d;
   logic [nprobes-1:0]   last_q, last_d;
   logic [DROP_W-1:0]    drops_q, drops_d;

   logic [tsbits-1:0]    w_cnt;
   logic                 w_at_max;
   logic                 w_load1;
   logic                 w_inc;
   logic                 w_changed;
   logic                 w_ine;
   logic [tsbits-1:0]    w_rec_d;
   logic [nprobes-1:0]   w_rec_v;
   logic [nprobes-1:0]   w_drops_ext;
   logic [width-1:0]     w_out;
   logic                 w_trig_hit;

   capture_delta #(.tsbits(tsbits)) u_delta (
      .clk    (clk),
      .reset  (reset),
      .load1  (w_load1),
      .inc    (w_inc),
      .cnt    (w_cnt),
      .at_max (w_at_max)
   );

`ifdef WIRE_CAPTURE_TRIG_EN
   assign w_trig_hit = ((sample_q & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
`else
   assign w_trig_hit = 1'b1;
`endif

   assign w_changed = (sample_q != last_q);
   assign sample_d  = bus.probe;

   always_comb begin
      w_drops_ext                = '0;
      w_drops_ext[DROP_W-1:0]    = drops_q;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      drops_d = drops_q;
      w_load1 = 1'b0;
      w_inc   = 1'b0;
      w_ine   = 1'b0;
      w_rec_d = '0;
      w_rec_v = '0;

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
`ifdef WIRE_CAPTURE_TRIG_EN
               state_d = ST_WAIT;
`else
               state_d = ST_START;
`endif
            end
         end

         ST_WAIT: begin
            if (w_trig_hit) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            w_ine   = 1'b1;
            w_rec_d = c_dmax;
            w_rec_v = sample_q;
            if (!bus.full) begin
               last_d  = sample_q;
               w_load1 = 1'b1;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (w_changed || w_at_max) begin
               w_ine   = 1'b1;
               w_rec_d = w_cnt;
               w_rec_v = sample_q;
               // The refused value is counted as drop #1, so last tracks it to
               // keep OVF from counting the same change a second time.
               last_d  = sample_q;
               if (!bus.full) begin
                  w_load1 = 1'b1;
               end else begin
                  drops_d = {{(DROP_W-1){1'b0}}, 1'b1};
                  state_d = ST_OVF;
               end
            end else begin
               w_inc = 1'b1;
            end
         end

         ST_OVF: begin
            w_ine   = 1'b1;
            w_rec_d = c_d_ovf;
            w_rec_v = w_drops_ext;
            last_d  = sample_q;
            if (w_changed) begin
               drops_d = drops_inc(drops_q);
            end
            if (!bus.full) begin
               state_d = ST_START;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disarm overrides the transition but the current offer still stands.
      if (!arm) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sample_q <= '0;
         last_q   <= '0;
         drops_q  <= '0;
      end else begin
         state_q  <= state_d;
         sample_q <= sample_d;
         last_q   <= last_d;
         drops_q  <= drops_d;
      end
   end

   assign w_out   = {w_rec_d, w_rec_v};
   assign bus.out = w_out;
   assign bus.ine = w_ine;

endmodule

`default_nettype wire
